// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg
// Shared definitions for the mMIPS program-counter stage:
//   - word and jump-index widths
//   - default reset PC
//   - FSM state encoding (2 bits)
//   - word-alignment helper
package pc_unit_pkg;

    localparam int WORD_W = 32;
    localparam int JIDX_W = 26;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2
    } pc_state_t;

    // Clears the byte-offset bits so a value can only ever name a whole word.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if
// Bundles the fetch-stage control inputs and the instruction-memory handshake.
//   master : the PC stage (drives imem_req, imem_addr, pc, pc_plus4, instr_valid)
//   slave  : its environment (drives stall, redirects, imm_shifted, imem_ack)
interface pc_unit_if;
    import pc_unit_pkg::*;

    logic              stall;
    logic              branch_taken;
    logic [WORD_W-1:0] imm_shifted;
    logic              jump;
    logic [JIDX_W-1:0] jump_index;
    logic              imem_ack;
    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic              instr_valid;

    modport master (
        input  stall, branch_taken, imm_shifted, jump, jump_index, imem_ack,
        output imem_req, imem_addr, pc, pc_plus4, instr_valid
    );

    modport slave (
        output stall, branch_taken, imm_shifted, jump, jump_index, imem_ack,
        input  imem_req, imem_addr, pc, pc_plus4, instr_valid
    );

endinterface

// File: rtl/pc_unit_target_calc.sv
// pc_target_calc
// Combinational target arithmetic for the PC stage, all modulo 2^32.
//   i_pc            current PC
//   i_imm_shifted   sign-extended offset << 2 (bits [1:0] ignored)
//   i_jump_index    instr[25:0] of a jump
//   o_pc_plus4      pc + 4
//   o_branch_target pc + 4 + offset
//   o_jump_target   {pc_plus4[31:28], jump_index, 2'b00}
module pc_target_calc
    import pc_unit_pkg::*;
(
    input  logic [WORD_W-1:0] i_pc,
    input  logic [WORD_W-1:0] i_imm_shifted,
    input  logic [JIDX_W-1:0] i_jump_index,
    output logic [WORD_W-1:0] o_pc_plus4,
    output logic [WORD_W-1:0] o_branch_target,
    output logic [WORD_W-1:0] o_jump_target
);

    logic [WORD_W-1:0] w_pc_plus4;

    assign w_pc_plus4      = i_pc + 32'd4;
    // Wrap-around past 0xFFFF_FFFC is intended; no overflow detection.
    assign o_branch_target = w_pc_plus4 + word_align(i_imm_shifted);
    assign o_jump_target   = {w_pc_plus4[WORD_W-1:WORD_W-4], i_jump_index, 2'b00};
    assign o_pc_plus4      = w_pc_plus4;

endmodule

// File: rtl/pc_unit.sv
// pc_unit
// Program-counter stage of the mMIPS fetch path: holds the PC, selects the
// next PC and runs the request/acknowledge handshake to instruction memory.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  pc_unit_if.master (stall/redirect inputs, imem handshake, pc outputs)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RESET | in reset; no request; leaves on first edge with rst=1
// S_REQ   | imem_req high, waiting for imem_ack (or streaming on ack)
// S_HOLD  | word accepted under stall; request low, pc frozen
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    pc_unit_if.master   bus
);

    localparam logic [WORD_W-1:0] RESET_PC_W = RESET_PC & ~32'h0000_0003;

    pc_state_t         r_state;
    logic [WORD_W-1:0] r_pc;
    logic              r_imem_req;
    logic              r_instr_valid;
    logic              r_redir_valid;
    logic [WORD_W-1:0] r_redir_target;

    logic [WORD_W-1:0] w_pc_plus4;
    logic [WORD_W-1:0] w_branch_target;
    logic [WORD_W-1:0] w_jump_target;
    logic              w_new_redirect;
    logic [WORD_W-1:0] w_redirect_target;
    logic [WORD_W-1:0] w_next_pc;

    pc_target_calc u_target_calc (
        .i_pc            (r_pc),
        .i_imm_shifted   (bus.imm_shifted),
        .i_jump_index    (bus.jump_index),
        .o_pc_plus4      (w_pc_plus4),
        .o_branch_target (w_branch_target),
        .o_jump_target   (w_jump_target)
    );

    assign w_new_redirect    = bus.jump | bus.branch_taken;
    assign w_redirect_target = bus.jump ? w_jump_target : w_branch_target;

    // A redirect captured while a fetch was outstanding outranks whatever
    // is presented at the advance itself.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (r_redir_valid) begin
            w_next_pc = r_redir_target;
        end else if (bus.jump) begin
            w_next_pc = w_jump_target;
        end else if (bus.branch_taken) begin
            w_next_pc = w_branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_RESET;
            r_pc           <= RESET_PC_W;
            r_imem_req     <= 1'b0;
            r_instr_valid  <= 1'b0;
            r_redir_valid  <= 1'b0;
            r_redir_target <= '0;
        end else begin
            r_instr_valid <= 1'b0;
            case (r_state)
                S_RESET: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (bus.imem_ack) begin
                        if (!bus.stall) begin
                            r_pc          <= word_align(w_next_pc);
                            r_instr_valid <= 1'b1;
                            r_redir_valid <= 1'b0;
                        end else begin
                            r_state    <= S_HOLD;
                            r_imem_req <= 1'b0;
                        end
                    end else if (w_new_redirect) begin
                        // The outstanding fetch cannot be aborted; remember
                        // the newest target for the next advance.
                        r_redir_valid  <= 1'b1;
                        r_redir_target <= w_redirect_target;
                    end
                end
                S_HOLD: begin
                    if (!bus.stall) begin
                        r_pc          <= word_align(w_next_pc);
                        r_instr_valid <= 1'b1;
                        r_redir_valid <= 1'b0;
                        r_state       <= S_REQ;
                        r_imem_req    <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_RESET;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.imem_addr   = r_pc;
    assign bus.pc_plus4    = w_pc_plus4;
    assign bus.imem_req    = r_imem_req;
    assign bus.instr_valid = r_instr_valid;

endmodule
